control_bubble_pipe: RTL and testbench

Parametrised control-bundle pipeline for the pipelined RISC-V core: carries the decoded control word (Branch, Jal, Jalr, MemRead, MemWrite, MemToReg, RegWrite, AluSrc, ALUOp) from decode through NStages registered stages, with a valid bit per stage. It adds hazard bubbles by injecting an all-zero control word at stage 0. Bubbles are single-cycle or multi-cycle via a countdown. It also provides per-stage flush for taken branches and jumps, and a global hold for memory waits. It sits between the control unit and the ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/control_bubble_pipe.sv | 109 ++++++++++
 tb/tb_control_bubble_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_bubble_pipe.sv
// Control-word pipeline with bubble injection, per-stage flush and global hold.
// Ports: clk, reset (sync, active-low), ctrl_i/valid_i in; insert_i, multi_i,
//   multi_count_i (bubbles); flush_i (per stage); hold_i (freeze);
//   stage_ctrl_o/stage_valid_o (all stages), ctrl_o/valid_o (last stage),
//   stall_o (comb upstream hold), bubble_active_o/bubble_cnt_o (counter).
module control_bubble_pipe #(
  parameter int NBits   = 11,
  parameter int NStages = 3,
  parameter int CntBits = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NBits-1:0]         ctrl_i,
  input  logic                     valid_i,
  input  logic                     insert_i,
  input  logic                     multi_i,
  input  logic [CntBits-1:0]       multi_count_i,
  input  logic [NStages-1:0]       flush_i,
  input  logic                     hold_i,
  output logic [NStages*NBits-1:0] stage_ctrl_o,
  output logic [NStages-1:0]       stage_valid_o,
  output logic [NBits-1:0]         ctrl_o,
  output logic                     valid_o,
  output logic                     stall_o,
  output logic                     bubble_active_o,
  output logic [CntBits-1:0]       bubble_cnt_o
);

  logic [NBits-1:0]   stage_q [NStages];
  logic [NBits-1:0]   stage_d [NStages];
  logic [NStages-1:0] valid_q;
  logic [NStages-1:0] valid_d;
  logic [CntBits-1:0] cnt_q;
  logic [CntBits-1:0] cnt_d;
  logic               multi_go;
  logic               inj;

  // A zero-length multi request is ignored entirely.
  assign multi_go = multi_i & (multi_count_i != '0);
  assign inj      = insert_i | multi_go | (cnt_q != '0);
  assign stall_o  = hold_i | inj;

  // Stage 0: flush beats hold beats advance.
  always_comb begin
    stage_d[0] = stage_q[0];
    valid_d[0] = valid_q[0];
    if (flush_i[0]) begin
      stage_d[0] = '0;
      valid_d[0] = 1'b0;
    end else if (!hold_i) begin
      stage_d[0] = inj ? '0 : ctrl_i;
      valid_d[0] = ~inj & valid_i;
    end
  end

  // Later stages take the pre-edge value of the stage ahead.
  for (genvar k = 1; k < NStages; k++) begin : g_adv
    always_comb begin
      stage_d[k] = stage_q[k];
      valid_d[k] = valid_q[k];
      if (flush_i[k]) begin
        stage_d[k] = '0;
        valid_d[k] = 1'b0;
      end else if (!hold_i) begin
        stage_d[k] = stage_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // The request edge is itself the first bubble, hence count-1.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (multi_go) begin
        cnt_d = multi_count_i - CntBits'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntBits'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NStages; k++) begin
        stage_q[k] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < NStages; k++) begin
        stage_q[k] <= stage_d[k];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NStages; k++) begin : g_out
    assign stage_ctrl_o[k*NBits +: NBits] = stage_q[k];
  end

  assign stage_valid_o   = valid_q;
  assign ctrl_o          = stage_q[NStages-1];
  assign valid_o         = valid_q[NStages-1];
  assign bubble_active_o = (cnt_q != '0);
  assign bubble_cnt_o    = cnt_q;

endmodule

// File: tb/tb_control_bubble_pipe.sv
// Self-checking bench for control_bubble_pipe at default parameters.
// Scoreboard queues hold expected post-edge state pushed at drive time.
module tb_control_bubble_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ctrl_i;
  logic        valid_i;
  logic        insert_i;
  logic        multi_i;
  logic [2:0]  multi_count_i;
  logic [2:0]  flush_i;
  logic        hold_i;
  logic [32:0] stage_ctrl_o;
  logic [2:0]  stage_valid_o;
  logic [10:0] ctrl_o;
  logic        valid_o;
  logic        stall_o;
  logic        bubble_active_o;
  logic [2:0]  bubble_cnt_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [32:0] w;
    logic [2:0]  v;
    logic [2:0]  c;
  } exp_t;

  exp_t        q[$];
  logic [11:0] oq[$];

  control_bubble_pipe dut (
    .clk(clk), .reset(reset), .ctrl_i(ctrl_i), .valid_i(valid_i),
    .insert_i(insert_i), .multi_i(multi_i),
    .multi_count_i(multi_count_i), .flush_i(flush_i), .hold_i(hold_i),
    .stage_ctrl_o(stage_ctrl_o), .stage_valid_o(stage_valid_o),
    .ctrl_o(ctrl_o), .valid_o(valid_o), .stall_o(stall_o),
    .bubble_active_o(bubble_active_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ctrl_i = '0; valid_i = 0; insert_i = 0; multi_i = 0;
    multi_count_i = '0; flush_i = '0; hold_i = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    ctrl_i = 11'h7FF;
    valid_i = 1;
    tick();
    tick();
    checks++;
    if (stage_ctrl_o !== 33'h0) begin
      errors++;
      $display("FAIL rst_words: got %h want 0", stage_ctrl_o);
    end
    checks++;
    if ({stage_valid_o, valid_o, ctrl_o} !== 15'h0) begin
      errors++;
      $display("FAIL rst_out: got v=%b vo=%b c=%h want 0",
               stage_valid_o, valid_o, ctrl_o);
    end
    checks++;
    if ({stall_o, bubble_active_o, bubble_cnt_o} !== 5'h0) begin
      errors++;
      $display("FAIL rst_cnt: got st=%b a=%b c=%0d want 0",
               stall_o, bubble_active_o, bubble_cnt_o);
    end
  endtask

  task automatic test_latency();
    logic [11:0] e;
    reset = 1;
    ctrl_i = 11'h7FF;
    valid_i = 1;
    oq.push_back(12'h000);
    oq.push_back(12'h000);
    oq.push_back({1'b1, 11'h7FF});
    oq.push_back(12'h000);
    oq.push_back(12'h000);
    for (int i = 0; i < 5; i++) begin
      tick();
      ctrl_i = '0;
      valid_i = 0;
      e = oq.pop_front();
      checks++;
      if ({valid_o, ctrl_o} !== e) begin
        errors++;
        $display("FAIL latency edge%0d: got %h want %h",
                 i + 1, {valid_o, ctrl_o}, e);
      end
    end
  endtask

  task automatic test_insert();
    logic [10:0] cv [4] = '{11'h001, 11'h002, 11'h002, 11'h003};
    logic [3:0]  ins = 4'b0010;
    logic [10:0] s0 [4] = '{11'h001, 11'h000, 11'h002, 11'h003};
    logic [3:0]  v0 = 4'b1101;
    logic [11:0] e;
    idle();
    for (int i = 0; i < 4; i++) begin
      ctrl_i = cv[i];
      valid_i = 1;
      insert_i = ins[i];
      #1;
      checks++;
      if (stall_o !== ins[i]) begin
        errors++;
        $display("FAIL ins_stall%0d: got %b want %b", i, stall_o, ins[i]);
      end
      oq.push_back({v0[i], s0[i]});
      tick();
      e = oq.pop_front();
      checks++;
      if ({stage_valid_o[0], stage_ctrl_o[10:0]} !== e) begin
        errors++;
        $display("FAIL ins_s0_%0d: got %h want %h", i,
                 {stage_valid_o[0], stage_ctrl_o[10:0]}, e);
      end
    end
  endtask

  task automatic test_multi();
    logic [3:0]  st = 4'b0111;
    logic [2:0]  cn [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
    logic [10:0] s0 [4] = '{11'h0, 11'h0, 11'h0, 11'h055};
    exp_t e;
    idle();
    ctrl_i = 11'h055;
    valid_i = 1;
    multi_count_i = 3'd3;
    for (int i = 0; i < 4; i++) begin
      multi_i = (i == 0);
      #1;
      checks++;
      if (stall_o !== st[i]) begin
        errors++;
        $display("FAIL multi_stall%0d: got %b want %b", i, stall_o, st[i]);
      end
      q.push_back('{w: {22'h0, s0[i]}, v: {2'b0, (i == 3)}, c: cn[i]});
      tick();
      e = q.pop_front();
      checks++;
      if ({bubble_cnt_o, bubble_active_o} !== {e.c, (e.c != 0)}) begin
        errors++;
        $display("FAIL multi_cnt%0d: got %0d/%b want %0d", i,
                 bubble_cnt_o, bubble_active_o, e.c);
      end
      checks++;
      if ({stage_valid_o[0], stage_ctrl_o[10:0]} !==
          {e.v[0], e.w[10:0]}) begin
        errors++;
        $display("FAIL multi_s0_%0d: got %h want %h", i,
                 stage_ctrl_o[10:0], e.w[10:0]);
      end
    end
  endtask

  task automatic test_multi_hold();
    logic [4:0]  mu = 5'b00001;
    logic [4:0]  ho = 5'b00010;
    logic [4:0]  st = 5'b01111;
    logic [2:0]  cn [5] = '{3'd2, 3'd2, 3'd1, 3'd0, 3'd0};
    logic [32:0] ws [5] = '{{11'h0, 11'h055, 11'h0}, {11'h0, 11'h055, 11'h0},
                           {11'h055, 11'h0, 11'h0}, 33'h0,
                           {22'h0, 11'h0AA}};
    logic [2:0]  vs [5] = '{3'b010, 3'b010, 3'b100, 3'b000, 3'b001};
    exp_t e;
    idle();
    ctrl_i = 11'h0AA;
    valid_i = 1;
    multi_count_i = 3'd3;
    for (int i = 0; i < 5; i++) begin
      multi_i = mu[i];
      hold_i = ho[i];
      #1;
      checks++;
      if (stall_o !== st[i]) begin
        errors++;
        $display("FAIL mh_stall%0d: got %b want %b", i, stall_o, st[i]);
      end
      q.push_back('{w: ws[i], v: vs[i], c: cn[i]});
      tick();
      e = q.pop_front();
      checks++;
      if ({stage_ctrl_o, stage_valid_o, bubble_cnt_o} !== e) begin
        errors++;
        $display("FAIL mh_edge%0d: got %h/%b/%0d want %h/%b/%0d", i,
                 stage_ctrl_o, stage_valid_o, bubble_cnt_o, e.w, e.v, e.c);
      end
    end
  endtask

  task automatic test_flush();
    logic [10:0] cv [5] = '{11'h300, 11'h200, 11'h100, 11'h400, 11'h500};
    logic [2:0]  fl [5] = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b100};
    logic [4:0]  ho = 5'b10000;
    logic [32:0] ws [5] = '{{11'h0, 11'h0AA, 11'h300},
                           {11'h0AA, 11'h300, 11'h200},
                           {11'h300, 11'h200, 11'h100},
                           {11'h200, 11'h0, 11'h0}, 33'h0};
    logic [2:0]  vs [5] = '{3'b011, 3'b111, 3'b111, 3'b100, 3'b000};
    exp_t e;
    idle();
    valid_i = 1;
    for (int i = 0; i < 5; i++) begin
      ctrl_i = cv[i];
      flush_i = fl[i];
      hold_i = ho[i];
      q.push_back('{w: ws[i], v: vs[i], c: 3'd0});
      tick();
      e = q.pop_front();
      checks++;
      if ({stage_ctrl_o, stage_valid_o} !== {e.w, e.v}) begin
        errors++;
        $display("FAIL flush_edge%0d: got %h/%b want %h/%b", i,
                 stage_ctrl_o, stage_valid_o, e.w, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    ctrl_i = 11'h123;
    valid_i = 1;
    multi_i = 1;
    multi_count_i = 3'd3;
    tick();
    checks++;
    if (bubble_cnt_o !== 3'd2) begin
      errors++;
      $display("FAIL rm_pre: got %0d want 2", bubble_cnt_o);
    end
    multi_i = 0;
    hold_i = 1;
    reset = 0;
    tick();
    checks++;
    if ({stage_ctrl_o, stage_valid_o, bubble_cnt_o, bubble_active_o}
        !== 40'h0) begin
      errors++;
      $display("FAIL rm_clear: got %h/%b/%0d/%b want 0", stage_ctrl_o,
               stage_valid_o, bubble_cnt_o, bubble_active_o);
    end
    reset = 1;
    idle();
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_stall_idle: got %b want 0", stall_o);
    end
    insert_i = 1;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL rm_stall_ins: got %b want 1", stall_o);
    end
    insert_i = 0;
    multi_i = 1;
    multi_count_i = 3'd0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_multi_stall: got %b want 0", stall_o);
    end
    tick();
    checks++;
    if ({bubble_cnt_o, bubble_active_o} !== 4'h0) begin
      errors++;
      $display("FAIL zero_multi_cnt: got %0d want 0", bubble_cnt_o);
    end
  endtask

  initial begin
    reset = 0;
    idle();
    test_reset();
    test_latency();
    test_insert();
    test_multi();
    test_multi_hold();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
